// File: rtl/k6502_sequencer.sv
// Instruction-timing sequencer for the k6502 core: owns the instruction register and the one-hot
// execute-cycle vector that index the microcode decoder. It also injects the interrupt opcode.
module k6502_sequencer #(
  parameter int          CYC_W      = 6,
  parameter logic [7:0]  INT_OPCODE = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic [7:0]       data_in,
  input  logic             sync_next,
  input  logic             irq_n,
  input  logic             nmi_n,
  input  logic             i_flag,
  output logic [7:0]       ir,
  output logic [CYC_W-1:0] cycle,
  output logic             sync,
  output logic             int_ack,
  output logic [1:0]       int_src,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_t;

  localparam logic [CYC_W-1:0] CYC_ZERO  = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_FIRST = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [7:0]       r_ir;
  logic [CYC_W-1:0] r_cycle;
  logic             r_int_ack;
  logic [1:0]       r_int_src;
  logic             r_overrun;
  logic             r_nmi_pend;
  logic             r_nmi_prev;

  state_t           w_state_nxt;
  logic [7:0]       w_ir_nxt;
  logic [CYC_W-1:0] w_cycle_nxt;
  logic             w_int_ack_nxt;
  logic [1:0]       w_int_src_nxt;
  logic             w_overrun_nxt;
  logic             w_nmi_take;
  logic             w_nmi_fall;
  logic             w_nmi_pend_nxt;

  // A falling edge arriving in the same clock as a consuming fetch survives as a fresh pending NMI.
  assign w_nmi_fall     = r_nmi_prev & ~nmi_n;
  assign w_nmi_pend_nxt = (r_nmi_pend & ~w_nmi_take) | w_nmi_fall;

  // Next-state, cycle-vector and opcode-select logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_ir_nxt      = r_ir;
    w_cycle_nxt   = r_cycle;
    w_int_ack_nxt = 1'b0;
    w_int_src_nxt = r_int_src;
    w_overrun_nxt = r_overrun;
    w_nmi_take    = 1'b0;
    if (rdy) begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_FETCH;
          w_cycle_nxt = CYC_ZERO;
        end
        ST_FETCH: begin
          w_state_nxt = ST_EXEC;
          w_cycle_nxt = CYC_FIRST;
          if (r_nmi_pend) begin
            w_ir_nxt      = INT_OPCODE;
            w_int_src_nxt = 2'b10;
            w_int_ack_nxt = 1'b1;
            w_nmi_take    = 1'b1;
          end else if (!irq_n && !i_flag) begin
            w_ir_nxt      = INT_OPCODE;
            w_int_src_nxt = 2'b01;
            w_int_ack_nxt = 1'b1;
          end else begin
            w_ir_nxt      = data_in;
            w_int_src_nxt = 2'b00;
          end
        end
        ST_EXEC: begin
          if (sync_next) begin
            w_state_nxt = ST_FETCH;
            w_cycle_nxt = CYC_ZERO;
          end else if (r_cycle[CYC_W-1]) begin
            // Ran off the end of the cycle vector: flag it and recover with a fresh fetch.
            w_overrun_nxt = 1'b1;
            w_state_nxt   = ST_FETCH;
            w_cycle_nxt   = CYC_ZERO;
          end else begin
            w_cycle_nxt = r_cycle << 1;
          end
        end
        default: begin
          w_state_nxt = ST_BOOT;
          w_cycle_nxt = CYC_ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Sequencing state; int_ack and the NMI detector advance regardless of rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_ir       <= 8'h00;
      r_cycle    <= CYC_ZERO;
      r_int_ack  <= 1'b0;
      r_int_src  <= 2'b00;
      r_overrun  <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_nmi_prev <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_ir       <= w_ir_nxt;
      r_cycle    <= w_cycle_nxt;
      r_int_ack  <= w_int_ack_nxt;
      r_int_src  <= w_int_src_nxt;
      r_overrun  <= w_overrun_nxt;
      r_nmi_pend <= w_nmi_pend_nxt;
      r_nmi_prev <= nmi_n;
    end
  end

  assign ir      = r_ir;
  assign cycle   = r_cycle;
  assign sync    = (r_state == ST_FETCH);
  assign int_ack = r_int_ack;
  assign int_src = r_int_src;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_k6502_sequencer.sv
// Directed bench for k6502_sequencer: the bench plays the decoder by driving sync_next per cycle
// and compares outputs #1 after each rising edge against hand-computed values.
module tb_k6502_sequencer;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic [7:0] data_in;
  logic       sync_next;
  logic       irq_n;
  logic       nmi_n;
  logic       i_flag;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       sync;
  logic       int_ack;
  logic [1:0] int_src;
  logic       overrun;

  int n_cmp;
  int n_bad;

  k6502_sequencer #(.CYC_W(6), .INT_OPCODE(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .data_in   (data_in),
    .sync_next (sync_next),
    .irq_n     (irq_n),
    .nmi_n     (nmi_n),
    .i_flag    (i_flag),
    .ir        (ir),
    .cycle     (cycle),
    .sync      (sync),
    .int_ack   (int_ack),
    .int_src   (int_src),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp = n_cmp + 1;
    if (obs !== exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_ir, input logic [5:0] e_cyc,
                           input logic e_sync, input logic e_ack, input logic [1:0] e_src,
                           input logic e_ovr);
    check({tag, ".ir"},      {24'h0, ir},      {24'h0, e_ir});
    check({tag, ".cycle"},   {26'h0, cycle},   {26'h0, e_cyc});
    check({tag, ".sync"},    {31'h0, sync},    {31'h0, e_sync});
    check({tag, ".int_ack"}, {31'h0, int_ack}, {31'h0, e_ack});
    check({tag, ".int_src"}, {30'h0, int_src}, {30'h0, e_src});
    check({tag, ".overrun"}, {31'h0, overrun}, {31'h0, e_ovr});
  endtask

  initial begin
    logic [5:0] exp_cyc;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    rdy       = 1'b1;
    data_in   = 8'h4C;
    sync_next = 1'b0;
    irq_n     = 1'b1;
    nmi_n     = 1'b1;
    i_flag    = 1'b1;

    step();
    check_all("reset", 8'h00, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    rst_n = 1'b1;
    check_all("boot", 8'h00, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    check_all("fetch0", 8'h00, 6'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    check_all("jmp.c1", 8'h4C, 6'b000001, 1'b0, 1'b0, 2'b00, 1'b0);

    // JMP abs with a 3-clock rdy stall on the second cycle
    sync_next = 1'b0;
    step();
    check_all("jmp.c2", 8'h4C, 6'b000010, 1'b0, 1'b0, 2'b00, 1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("stall", 8'h4C, 6'b000010, 1'b0, 1'b0, 2'b00, 1'b0);
    end
    rdy = 1'b1;
    step();
    check_all("jmp.c3", 8'h4C, 6'b000100, 1'b0, 1'b0, 2'b00, 1'b0);
    sync_next = 1'b1;
    data_in   = 8'hEA;
    step();
    check_all("jmp.end", 8'h4C, 6'd0, 1'b1, 1'b0, 2'b00, 1'b0);

    // NMI falling edge during EXEC, nmi_n then held low
    step();
    check_all("nop.c1", 8'hEA, 6'b000001, 1'b0, 1'b0, 2'b00, 1'b0);
    sync_next = 1'b0;
    nmi_n     = 1'b0;
    step();
    check_all("nop.c2", 8'hEA, 6'b000010, 1'b0, 1'b0, 2'b00, 1'b0);
    sync_next = 1'b1;
    step();
    check("nmi.pre_sync", {31'h0, sync}, 32'd1);
    step();
    check_all("nmi.take", 8'h00, 6'b000001, 1'b0, 1'b1, 2'b10, 1'b0);
    step();
    check_all("nmi.ackclr", 8'h00, 6'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    check_all("nmi.noretrig", 8'hEA, 6'b000001, 1'b0, 1'b0, 2'b00, 1'b0);
    nmi_n = 1'b1;

    // IRQ masked, then unmasked
    step();
    irq_n  = 1'b0;
    i_flag = 1'b1;
    step();
    check_all("irq.masked", 8'hEA, 6'b000001, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    i_flag = 1'b0;
    step();
    check_all("irq.take", 8'h00, 6'b000001, 1'b0, 1'b1, 2'b01, 1'b0);
    irq_n  = 1'b1;
    i_flag = 1'b1;
    rdy    = 1'b0;
    step();
    check_all("irq.ack_rdy0", 8'h00, 6'b000001, 1'b0, 1'b0, 2'b01, 1'b0);
    rdy = 1'b1;

    // Overrun: sync_next held low through all six cycles
    step();
    check("ovr.fetch", {31'h0, sync}, 32'd1);
    data_in   = 8'h02;
    sync_next = 1'b0;
    step();
    check_all("ovr.c1", 8'h02, 6'b000001, 1'b0, 1'b0, 2'b00, 1'b0);
    exp_cyc = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      exp_cyc = {exp_cyc[4:0], 1'b0};
      step();
      check_all("ovr.walk", 8'h02, exp_cyc, 1'b0, 1'b0, 2'b00, 1'b0);
    end
    step();
    check_all("ovr.flag", 8'h02, 6'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    step();
    check_all("ovr.sticky", 8'h02, 6'b000001, 1'b0, 1'b0, 2'b00, 1'b1);
    step();
    check_all("ovr.c2", 8'h02, 6'b000010, 1'b0, 1'b0, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/k6502_sequencer.md
Name: k6502_sequencer

Overview:
Instruction-timing sequencer for the k6502 core. It owns the instruction register and the one-hot cycle vector that together index the microcode decoder. It consumes the decoder's SYNC_NEXT bit to end each instruction, fetches the next opcode, and injects the interrupt opcode when NMI or IRQ is pending. It sits between the bus interface (data_in, rdy) and the microcode decoder.

Parameters:
CYC_W, 6, width of the one-hot cycle vector; also the maximum number of execute cycles per instruction.
INT_OPCODE, 8'h00, opcode loaded into ir when an interrupt is taken.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
rdy  input  1  bus ready; when 0, all sequencing state holds.
data_in  input  8  read data bus; sampled as the opcode at the end of a fetch cycle.
sync_next  input  1  SYNC_NEXT bit from the microcode word for the current {ir, cycle}.
irq_n  input  1  level-sensitive interrupt request, active-low.
nmi_n  input  1  edge-sensitive non-maskable interrupt, active-low.
i_flag  input  1  processor I flag; 1 masks IRQ.
ir  output  8  instruction register to the decoder.
cycle  output  CYC_W  one-hot execute cycle to the decoder; all zeros during fetch.
sync  output  1  1 during an opcode-fetch cycle.
int_ack  output  1  one-cycle pulse on the edge that injects INT_OPCODE.
int_src  output  2  source of the current instruction: 00 normal, 01 IRQ, 10 NMI. Held until the next fetch completes.
overrun  output  1  sticky error flag: an instruction ran past cycle bit CYC_W-1 without sync_next.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ir=8'h00, cycle=0, state=BOOT, sync=0, int_ack=0, int_src=00, overrun=0.
  - nmi_pend=0; the NMI edge register is set to 1.
- States: BOOT, FETCH, EXEC. All transitions below require rdy=1. With rdy=0 every register holds, except the NMI edge detector.
- BOOT: decoder sees {00, 0}. Go to FETCH on the next edge regardless of sync_next. sync=0.
- FETCH:
  - sync=1, cycle=0, and sync_next is ignored.
  - On the edge, state<=EXEC and cycle<=1 (bit 0 set).
  - Opcode select, in priority order:
    - nmi_pend=1: ir<=INT_OPCODE, int_src<=10, nmi_pend<=0, int_ack<=1.
    - Else irq_n=0 and i_flag=0: ir<=INT_OPCODE, int_src<=01, int_ack<=1.
    - Else: ir<=data_in, int_src<=00.
  - irq_n and i_flag are sampled only on this edge.
- EXEC:
  - sync=0.
  - sync_next=1: state<=FETCH, cycle<=0.
  - sync_next=0 with cycle bit CYC_W-1 clear: cycle<=cycle<<1.
  - sync_next=0 with cycle bit CYC_W-1 set: overrun<=1 (sticky), state<=FETCH, cycle<=0.
- int_ack is high for exactly one clock. It is cleared on the next edge even if rdy=0 on that edge.
- NMI detect:
  - A falling edge is nmi_n sampled 0 while the previous sample was 1. It sets nmi_pend. Sampling runs every clock, independent of rdy.
  - When a falling edge coincides with a FETCH edge that consumes nmi_pend, nmi_pend ends at 1; the new edge is not lost.
  - Holding nmi_n low does not re-trigger.
- The registers driving the cycle output are one-hot or zero at all times. No other encoding ever appears on cycle.
- The decoder output path is combinational: sync_next reflects the current ir/cycle within the same clock, with no added latency.
- overrun is cleared only by reset.

Test Plan:
- Reset, then release with rdy=1 and data_in=8'h4C. Required: ir/cycle read {00,0} in BOOT, then sync=1 and FETCH. On the next edge ir=8'h4C, cycle=000001, sync=0.
- JMP abs: ir=4C, sync_next=0,0,1 on cycles 000001, 000010, 000100. Required: cycle steps 1→2→4, then sync=1 and cycle=0 on the following clock.
- rdy=0 for 3 clocks while cycle=000010. Required: ir, cycle and state unchanged. Deassert rdy, then cycle=000100 one edge later.
- NMI: pulse nmi_n low during EXEC, with the next fetch data_in=8'hEA. Required: ir=8'h00, int_src=10, one-clock int_ack. A second fetch with nmi_n still low loads 8'hEA and int_src=00.
- IRQ masking: irq_n=0 with i_flag=1 at fetch, data_in=8'hEA. Required: ir=EA. Repeat with i_flag=0. Required: ir=00, int_src=01, int_ack pulse.
- Overrun: opcode with sync_next held 0. Required: cycle walks 1,2,4,8,16,32, then FETCH with overrun=1. Asserting rst_n=0 mid-EXEC immediately clears all outputs to their reset values, including overrun.
